// File: rtl/matrix_frame_scheduler.sv
// matrix_frame_scheduler: double-buffered 8x8 frame store with a two-requester write arbiter
// and frame-boundary buffer swap, so the matrix scan never shows a half-written frame.
module matrix_frame_scheduler #(
    parameter int FRAME_CYCLES = 839680
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req,
    output logic [1:0]      grant,
    input  logic [1:0]      wr_en,
    input  logic [1:0][2:0] wr_row,
    input  logic [1:0][7:0] wr_data,
    input  logic [1:0]      commit,
    output logic [7:0][7:0] frame_out,
    output logic            frame_tick,
    output logic            swap_pending,
    output logic            swap_pulse
);
    localparam int CW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, WAIT_SWAP} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [7:0][7:0] buf0, buf1;
    logic            idx, last, last_d, swap, wr_go, wr_sel;

    assign frame_tick   = cnt == LAST;
    assign swap         = state == WAIT_SWAP && frame_tick;
    assign grant        = {state == OWN1, state == OWN0};
    assign swap_pending = state == WAIT_SWAP;
    assign frame_out    = idx ? buf1 : buf0;
    assign wr_sel       = state == OWN1;
    assign wr_go        = (state == OWN0 && wr_en[0]) || (state == OWN1 && wr_en[1]);

    // last == 1 means requester 1 was served last, so requester 0 wins a tie
    always_comb begin
        state_d = state;
        last_d  = last;
        case (state)
            IDLE: begin
                if (req == 2'b11) begin
                    state_d = last ? OWN0 : OWN1;
                    last_d  = ~last;
                end else if (req[0]) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (req[1]) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0:      state_d = commit[0] ? WAIT_SWAP : (req[0] ? OWN0 : IDLE);
            OWN1:      state_d = commit[1] ? WAIT_SWAP : (req[1] ? OWN1 : IDLE);
            WAIT_SWAP: state_d = frame_tick ? IDLE : WAIT_SWAP;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            cnt        <= '0;
            idx        <= 1'b0;
            swap_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            last       <= last_d;
            cnt        <= frame_tick ? '0 : cnt + CW'(1);
            idx        <= idx ^ swap;
            swap_pulse <= swap;
        end
    end

    // the back buffer is whichever one idx does not select
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (wr_go) begin
            if (idx)
                buf0[wr_row[wr_sel]] <= wr_data[wr_sel];
            else
                buf1[wr_row[wr_sel]] <= wr_data[wr_sel];
        end
    end
endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// tb_matrix_frame_scheduler: directed stimulus with a frame scoreboard; a monitor checks
// every swap_pulse against queued expected frames and frame_tick against a scan-count model.
module tb_matrix_frame_scheduler;
    typedef logic [7:0][7:0] frame_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      req, grant, wr_en, commit;
    logic [1:0][2:0] wr_row;
    logic [1:0][7:0] wr_data;
    frame_t          frame_out;
    logic            frame_tick, swap_pending, swap_pulse;

    int     compared = 0;
    int     mismatched = 0;
    int     tcnt;
    frame_t exp_q[$];
    frame_t e;

    matrix_frame_scheduler #(.FRAME_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .wr_en(wr_en),
        .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .frame_out(frame_out),
        .frame_tick(frame_tick), .swap_pending(swap_pending), .swap_pulse(swap_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset)
        if (reset) tcnt <= 0;
        else tcnt <= (tcnt == 15) ? 0 : tcnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: frame_tick against the model count, frames against the scoreboard
    always @(negedge clk) begin
        chk("frame_tick", 64'(frame_tick), 64'(tcnt == 15));
        if (swap_pulse) begin
            if (exp_q.size() == 0) chk("unexpected_swap", 64'(1), 64'(0));
            else chk("swap_frame", frame_out, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while (tcnt != k && n < 64) begin
            step();
            n++;
        end
        if (tcnt != k) chk("wait_cnt_timeout", 64'(tcnt), 64'(k));
    endtask

    initial begin
        reset = 1'b1; req = '0; wr_en = '0; wr_row = '0; wr_data = '0; commit = '0;
        step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_pending", swap_pending, 0);
        chk("rst_pulse", swap_pulse, 0);
        chk("rst_frame", frame_out, 0);
        reset = 1'b0;
        repeat (40) step();
        chk("idle_grant", grant, 0);
        chk("idle_frame", frame_out, 0);

        // tie after reset goes to requester 0; requester 1 writes are ignored
        req = 2'b11;
        step();
        chk("tie_grant0", grant, 2'b01);
        for (int r = 0; r < 8; r++) begin
            wr_en = 2'b11;
            wr_row[0] = 3'(r); wr_data[0] = 8'h81;
            wr_row[1] = 3'd3;  wr_data[1] = 8'hFF;
            step();
        end
        wr_en = '0;
        wait_cnt(5);
        commit = 2'b01;
        exp_q.push_back({8{8'h81}});
        step();
        commit = '0;
        chk("commit_grant", grant, 0);
        chk("commit_pending", swap_pending, 1);
        wait_cnt(0);
        chk("swapA_pulse", swap_pulse, 1);
        chk("swapA_pending", swap_pending, 0);
        chk("swapA_frame", frame_out, {8{8'h81}});
        step();
        chk("tie_grant1", grant, 2'b10);
        chk("pulse_one_cycle", swap_pulse, 0);

        // requester 1 abandons its session; requester 0 then adds a row and commits on the tick
        req = 2'b10;
        wr_en = 2'b11;
        wr_row[1] = 3'd2; wr_data[1] = 8'h3C;
        wr_row[0] = 3'd2; wr_data[0] = 8'hFF;
        step();
        wr_en = '0; req = '0;
        step();
        chk("abandon_grant", grant, 0);
        chk("abandon_pending", swap_pending, 0);
        req = 2'b01;
        step();
        chk("single_grant0", grant, 2'b01);
        wr_en = 2'b01; wr_row[0] = 3'd5; wr_data[0] = 8'hA5;
        step();
        wr_en = '0;
        wait_cnt(15);
        commit = 2'b01;
        e = '0; e[2] = 8'h3C; e[5] = 8'hA5;
        exp_q.push_back(e);
        step();
        commit = '0; req = '0;
        chk("tick_commit_nopulse", swap_pulse, 0);
        chk("tick_commit_pending", swap_pending, 1);
        step();
        wait_cnt(0);
        chk("swapB_pulse", swap_pulse, 1);

        // the back buffer is the old front, untouched
        req = 2'b10;
        step();
        chk("grant1_again", grant, 2'b10);
        wait_cnt(3);
        commit = 2'b10;
        exp_q.push_back({8{8'h81}});
        step();
        commit = '0; req = '0;
        wait_cnt(0);
        chk("swapC_pulse", swap_pulse, 1);

        // reset while a frame is pending discards it
        req = 2'b01;
        step();
        wr_en = 2'b01; wr_row[0] = 3'd0; wr_data[0] = 8'h55; commit = 2'b01;
        step();
        wr_en = '0; commit = '0; req = '0;
        chk("pre_reset_pending", swap_pending, 1);
        reset = 1'b1;
        step();
        chk("mid_reset_pending", swap_pending, 0);
        chk("mid_reset_frame", frame_out, 0);
        reset = 1'b0;
        step();
        chk("post_reset_pending", swap_pending, 0);
        chk("post_reset_frame", frame_out, 0);
        chk("post_reset_grant", grant, 0);
        repeat (20) step();
        chk("post_reset_frame_late", frame_out, 0);
        chk("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/matrix_frame_scheduler.md
MATRIX_FRAME_SCHEDULER -- requirements
Module: matrix_frame_scheduler

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is asynchronous and active-high.
REQ-002 Parameter FRAME_CYCLES, default 839680, SHALL set the clk cycles in one full 8-row matrix scan (256 x 410 x 8).
REQ-003 Port clk, input, 1: rising-edge clock for all state.
REQ-004 Port reset, input, 1: asynchronous active-high clear of all state.
REQ-005 Port req, input, [1:0]: requester i asks for a frame-write session.
REQ-006 Port grant, output, [1:0]: one-hot or zero; requester i owns the back buffer.
REQ-007 Port wr_en, input, [1:0]: requester i row-write strobe.
REQ-008 Port wr_row, input, [1:0][2:0]: row index per requester.
REQ-009 Port wr_data, input, [1:0][7:0]: row pixels per requester, bit j = column j.
REQ-010 Port commit, input, [1:0]: requester i ends its session and requests display of the back buffer.
REQ-011 Port frame_out, output, [7:0][7:0]: front buffer, row-major, feeds the matrix converter data_in.
REQ-012 Port frame_tick, output, 1: one-cycle pulse on the last cycle of each scan period.
REQ-013 Port swap_pending, output, 1: a committed frame awaits the next frame boundary.
REQ-014 Port swap_pulse, output, 1: one-cycle pulse in the first cycle frame_out shows a new frame.

Function
REQ-015 The block SHALL hold two 8x8 buffers: front (drives frame_out) and back (write target), selected by a 1-bit index.
REQ-016 The scan counter SHALL count 0..FRAME_CYCLES-1 and wrap to 0; frame_tick SHALL be 1 only when the count is FRAME_CYCLES-1.
REQ-017 The arbiter FSM SHALL have states IDLE, OWN0, OWN1 and WAIT_SWAP.
REQ-018 In IDLE with exactly one req bit set, the FSM SHALL move to OWNi and assert grant[i] on the next cycle.
REQ-019 In IDLE with both req bits set, the FSM SHALL grant the requester not served last; after reset, requester 0 SHALL win.
REQ-020 In OWNi, wr_en[i] SHALL write wr_data[i] into back row wr_row[i] on that edge; the non-granted requester's wr_en, wr_row, wr_data and commit SHALL be ignored.
REQ-021 commit[i] in OWNi SHALL set swap_pending, deassert grant the next cycle and enter WAIT_SWAP; a wr_en[i] in the same cycle SHALL still be written.
REQ-022 If req[i] falls in OWNi without commit, the FSM SHALL return to IDLE with no swap; back-buffer contents SHALL be retained.
REQ-023 In WAIT_SWAP, no grant SHALL be issued regardless of req.
REQ-024 On a frame_tick cycle in WAIT_SWAP, the buffer index SHALL toggle, swap_pending SHALL clear and the FSM SHALL enter IDLE.
REQ-025 On the cycle after that edge, frame_out SHALL show the new front buffer and swap_pulse SHALL be 1 for exactly that cycle.
REQ-026 A commit in the same cycle as frame_tick SHALL NOT swap on that tick; the swap SHALL wait for the next tick.
REQ-027 After a swap, the back buffer SHALL be the previous front buffer, unmodified.
REQ-028 frame_out SHALL change only on a swap, never mid-scan, so each scan period displays exactly one frame.

Reset
REQ-029 While reset is high, both buffers SHALL be 0, index 0, scan counter 0, FSM in IDLE, the last-served pointer set to favour requester 0, and grant, frame_tick, swap_pending and swap_pulse all 0.
REQ-030 Reset mid-session or in WAIT_SWAP SHALL abort the session; the pending frame SHALL be discarded, and after release frame_out SHALL be all zero.

Verification (FRAME_CYCLES=16)
REQ-031 Reset release, no req for 40 cycles -> frame_tick on counts 15 and 31, frame_out all 0, grant 00, swap_pulse never 1.
REQ-032 req=01; write rows 0..7 = 8'h81; commit at count 5 -> grant 01 one cycle after req, swap_pending 1; at count 15 index toggles; next cycle frame_out rows all 8'h81, swap_pulse 1 for one cycle.
REQ-033 req=11 simultaneously after reset -> grant 01; after requester 0 commits and the swap completes, with req=11 again -> grant 10.
REQ-034 Requester 1 drives wr_en[1]=1, row 3, data 8'hFF while grant=01 -> back row 3 unchanged; frame_out after the next swap shows requester 0 data only.
REQ-035 commit on the frame_tick cycle (count 15) -> no swap_pulse at count 0; swap_pulse after count 15 of the following period.
REQ-036 reset pulsed while swap_pending=1 -> after release swap_pending 0, frame_out all 0, grant 00, no swap_pulse at the next tick.
